// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV32 pipeline front end.
//   XLEN             datapath / PC width
//   NOP_INSTR        canonical RV32I NOP (addi x0, x0, 0) used for bubbles
//   RESET_PC         default PC after reset (base of instruction memory map)
//   if_id_t          IF/ID pipeline register contents
//   if_id_bubble()   the all-inert IF/ID value used on reset and flush
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // A bubble decodes as a NOP and carries no PC so downstream link/branch
    // logic sees a clean zero rather than a stale address.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.instr    = NOP_INSTR;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Priority: rst, then flush (bubble), then stall
// (hold), otherwise capture the new fetch record.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset (loads a bubble)
//   stall   in   hold current contents
//   flush   in   replace contents with a bubble (wins over stall)
//   d       in   if_id_t record from the fetch stage
//   q       out  registered if_id_t record to decode
// ----------------------------------------------------------------------------
module if_id_reg
    import rv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q_reg <= if_id_bubble();
        end else if (!stall) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// IF stage of the pipelined RV32 core. Holds the program counter, presents it
// to a combinational instruction memory and captures the returned word into
// the IF/ID register.
//
// Parameters:
//   XLEN       datapath / PC width (must match rv_pkg::XLEN, which sizes if_id_t)
//   RESET_PC   PC loaded on reset
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   stall_f_i       in   hold PC (load-use hazard)
//   stall_d_i       in   hold IF/ID contents
//   flush_d_i       in   replace IF/ID contents with a bubble
//   pc_src_e_i      in   taken branch/jump resolved in EX
//   pc_target_e_i   in   redirect target from EX (bits [1:0] ignored)
//   pc_f_o          out  current fetch PC (registered) -> imem address
//   instr_f_i       in   imem read data for pc_f_o (same cycle)
//   instr_d_o       out  IF/ID instruction
//   pc_d_o          out  IF/ID PC
//   pc_plus4_d_o    out  IF/ID PC+4 (link value)
//   valid_d_o       out  IF/ID holds a real instruction
//
// Optional build macro FETCH_PERF_EN adds three 32-bit wrapping counters:
//   perf_fetch_cnt_o   valid IF/ID captures
//   perf_stall_cnt_o   cycles with stall_f_i=1 and no redirect
//   perf_flush_cnt_o   cycles with flush_d_i=1
// ----------------------------------------------------------------------------
module fetch_stage
    import rv_pkg::*;
#(
    parameter int              XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f_i,
    input  logic            stall_d_i,
    input  logic            flush_d_i,
    input  logic            pc_src_e_i,
    input  logic [XLEN-1:0] pc_target_e_i,
    output logic [XLEN-1:0] pc_f_o,
    input  logic [31:0]     instr_f_i,
    output logic [31:0]     instr_d_o,
    output logic [XLEN-1:0] pc_d_o,
    output logic [XLEN-1:0] pc_plus4_d_o,
    output logic            valid_d_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_stall_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;

    // Natural modulo-2^XLEN wrap; falling off the top of the map is not an error.
    assign pc_plus4 = pc_reg + XLEN'(4);

    // Redirect outranks stall: a resolved branch must land even while the
    // hazard unit is holding the front end, otherwise it would be lost.
    // Target is forced word-aligned (no compressed ISA, no misalign trap).
    always_comb begin
        pc_next = pc_plus4;
        if (pc_src_e_i) begin
            pc_next = pc_target_e_i & ~XLEN'(3);
        end else if (stall_f_i) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc_f_o = pc_reg;

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    if_id_t if_id_d;
    if_id_t if_id_q;

    always_comb begin
        if_id_d.instr    = instr_f_i;
        if_id_d.pc       = pc_reg;
        if_id_d.pc_plus4 = pc_plus4;
        if_id_d.valid    = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .stall (stall_d_i),
        .flush (flush_d_i),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign instr_d_o    = if_id_q.instr;
    assign pc_d_o       = if_id_q.pc;
    assign pc_plus4_d_o = if_id_q.pc_plus4;
    assign valid_d_o    = if_id_q.valid;

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters: index 0 fetch, 1 stall, 2 flush.
    // ------------------------------------------------------------------
    localparam int NUM_PERF = 3;

    logic [NUM_PERF-1:0] perf_inc;
    logic [31:0]         perf_cnt_reg [NUM_PERF];

    // A capture happens exactly when the IF/ID register loads a real record.
    assign perf_inc[0] = !flush_d_i && !stall_d_i;
    // A stall cycle that a redirect overrides is not a lost fetch slot.
    assign perf_inc[1] = stall_f_i && !pc_src_e_i;
    assign perf_inc[2] = flush_d_i;

    for (genvar gi = 0; gi < NUM_PERF; gi++) begin : g_perf
        always_ff @(posedge clk) begin
            if (rst) begin
                perf_cnt_reg[gi] <= '0;
            end else if (perf_inc[gi]) begin
                perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = perf_cnt_reg[0];
    assign perf_stall_cnt_o = perf_cnt_reg[1];
    assign perf_flush_cnt_o = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with a behavioural reference model and a
// per-cycle compare process. Build with +define+FETCH_PERF_EN to also cover
// the performance counters.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_f_i;
    logic        stall_d_i;
    logic        flush_d_i;
    logic        pc_src_e_i;
    logic [31:0] pc_target_e_i;
    logic [31:0] pc_f_o;
    logic [31:0] instr_f_i;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic        valid_d_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_flush_cnt_o;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f_i     (stall_f_i),
        .stall_d_i     (stall_d_i),
        .flush_d_i     (flush_d_i),
        .pc_src_e_i    (pc_src_e_i),
        .pc_target_e_i (pc_target_e_i),
        .pc_f_o        (pc_f_o),
        .instr_f_i     (instr_f_i),
        .instr_d_o     (instr_d_o),
        .pc_d_o        (pc_d_o),
        .pc_plus4_d_o  (pc_plus4_d_o),
        .valid_d_o     (valid_d_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: a distinct word per address.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        return {addr[31:2] ^ 30'h2A5B_3C4D, 2'b11};
    endfunction

    assign instr_f_i = imem(pc_f_o);

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the front end must hold after each edge,
    // derived straight from the fetch rules (redirect > stall > +4;
    // flush > stall > capture; reset overrides everything).
    // ------------------------------------------------------------------
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pcd   = '0;
    logic [31:0] m_pc4   = '0;
    logic        m_valid = 1'b0;
    int          m_fetch = 0;
    int          m_stall = 0;
    int          m_flush = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc    <= 32'h0;
            m_instr <= NOP;
            m_pcd   <= 32'h0;
            m_pc4   <= 32'h0;
            m_valid <= 1'b0;
            m_fetch <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (pc_src_e_i)     m_pc <= {pc_target_e_i[31:2], 2'b00};
            else if (!stall_f_i) m_pc <= m_pc + 32'd4;
            if (flush_d_i) begin
                m_instr <= NOP;
                m_pcd   <= 32'h0;
                m_pc4   <= 32'h0;
                m_valid <= 1'b0;
            end else if (!stall_d_i) begin
                m_instr <= imem(m_pc);
                m_pcd   <= m_pc;
                m_pc4   <= m_pc + 32'd4;
                m_valid <= 1'b1;
                m_fetch <= m_fetch + 1;
            end
            if (stall_f_i && !pc_src_e_i) m_stall <= m_stall + 1;
            if (flush_d_i)                m_flush <= m_flush + 1;
        end
    end

    // Compare process: every falling edge once the model has seen a reset.
    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc_f",      pc_f_o,               m_pc);
            chk("instr_d",   instr_d_o,            m_instr);
            chk("pc_d",      pc_d_o,               m_pcd);
            chk("pc_plus4_d", pc_plus4_d_o,        m_pc4);
            chk("valid_d",   {31'b0, valid_d_o},   {31'b0, m_valid});
`ifdef FETCH_PERF_EN
            chk("perf_fetch", perf_fetch_cnt_o,    32'(m_fetch));
            chk("perf_stall", perf_stall_cnt_o,    32'(m_stall));
            chk("perf_flush", perf_flush_cnt_o,    32'(m_flush));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; stall_f_i = 1'b0; stall_d_i = 1'b0;
        flush_d_i = 1'b0; pc_src_e_i = 1'b0; pc_target_e_i = 32'h0;
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // T1 reset
        tick();
        cmp_en = 1'b1;
        tick();
        $display("T1 reset: pc_f=0x%08h valid_d=%0b", pc_f_o, valid_d_o);
        chk("t1_pc_f",   pc_f_o,    32'h0);
        chk("t1_valid",  {31'b0, valid_d_o}, 32'h0);
        chk("t1_instr",  instr_d_o, NOP);
        chk("t1_pc_d",   pc_d_o,    32'h0);
        rst = 1'b0;
        tick();
        $display("T1 release: pc_f=0x%08h pc_d=0x%08h valid_d=%0b", pc_f_o, pc_d_o, valid_d_o);
        chk("t1_rel_pc_d",  pc_d_o,    32'h0);
        chk("t1_rel_valid", {31'b0, valid_d_o}, 32'h1);
        chk("t1_rel_instr", instr_d_o, imem(32'h0));
        chk("t1_rel_pc_f",  pc_f_o,    32'h4);

        // T2 sequential
        tick();
        tick();
        $display("T2 seq: pc_f=0x%08h pc_d=0x%08h pc4_d=0x%08h", pc_f_o, pc_d_o, pc_plus4_d_o);
        chk("t2_pc_f",   pc_f_o,       32'hC);
        chk("t2_pc_d",   pc_d_o,       32'h8);
        chk("t2_pc4_d",  pc_plus4_d_o, 32'hC);

        // T3 redirect beats stall, flush beats stall
        pc_src_e_i = 1'b1; pc_target_e_i = 32'h103; stall_f_i = 1'b1;
        flush_d_i = 1'b1; stall_d_i = 1'b1;
        tick();
        idle();
        $display("T3 redirect: pc_f=0x%08h instr_d=0x%08h valid_d=%0b", pc_f_o, instr_d_o, valid_d_o);
        chk("t3_pc_f",  pc_f_o,    32'h100);
        chk("t3_instr", instr_d_o, NOP);
        chk("t3_valid", {31'b0, valid_d_o}, 32'h0);
        tick();
        $display("T3 target in D: pc_d=0x%08h valid_d=%0b", pc_d_o, valid_d_o);
        chk("t3_tgt_pc_d",  pc_d_o, 32'h100);
        chk("t3_tgt_valid", {31'b0, valid_d_o}, 32'h1);

        // T4 stall hold at PC 0x20
        pc_src_e_i = 1'b1; pc_target_e_i = 32'h1C;
        tick();
        idle();
        tick();
        stall_f_i = 1'b1; stall_d_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("T4 stall %0d: pc_f=0x%08h pc_d=0x%08h", i, pc_f_o, pc_d_o);
            chk("t4_pc_f",  pc_f_o,    32'h20);
            chk("t4_pc_d",  pc_d_o,    32'h1C);
            chk("t4_instr", instr_d_o, imem(32'h1C));
        end
        // pc_f_o must not follow inputs combinationally.
        pc_src_e_i = 1'b1; pc_target_e_i = 32'h400;
        #1;
        chk("t4_pc_f_comb", pc_f_o, 32'h20);
        pc_src_e_i = 1'b0; pc_target_e_i = 32'h0;
        idle();
        tick();
        $display("T4 release: pc_f=0x%08h pc_d=0x%08h", pc_f_o, pc_d_o);
        chk("t4_rel_pc_f", pc_f_o, 32'h24);
        chk("t4_rel_pc_d", pc_d_o, 32'h20);

        // Flush alone, then stall_d alone
        flush_d_i = 1'b1;
        tick();
        idle();
        $display("flush only: pc_f=0x%08h valid_d=%0b", pc_f_o, valid_d_o);
        chk("fl_pc_f",  pc_f_o, 32'h28);
        chk("fl_valid", {31'b0, valid_d_o}, 32'h0);
        tick();
        stall_d_i = 1'b1;
        tick();
        idle();
        $display("stall_d only: pc_f=0x%08h pc_d=0x%08h", pc_f_o, pc_d_o);
        chk("sd_pc_f", pc_f_o, 32'h30);
        chk("sd_pc_d", pc_d_o, 32'h28);

        // T5 wrap (target low bits also masked)
        pc_src_e_i = 1'b1; pc_target_e_i = 32'hFFFF_FFFF;
        tick();
        idle();
        chk("t5_pc_f_top", pc_f_o, 32'hFFFF_FFFC);
        tick();
        $display("T5 wrap: pc_f=0x%08h pc_d=0x%08h pc4_d=0x%08h", pc_f_o, pc_d_o, pc_plus4_d_o);
        chk("t5_pc_f",  pc_f_o,       32'h0);
        chk("t5_pc_d",  pc_d_o,       32'hFFFF_FFFC);
        chk("t5_pc4_d", pc_plus4_d_o, 32'h0);

        // Mixed control patterns, checked cycle by cycle against the model.
        for (int i = 0; i < 60; i++) begin
            rst           = ($urandom_range(0, 15) == 0);
            stall_f_i     = ($urandom_range(0, 3) == 0);
            stall_d_i     = ($urandom_range(0, 3) == 0);
            flush_d_i     = ($urandom_range(0, 4) == 0);
            pc_src_e_i    = ($urandom_range(0, 5) == 0);
            pc_target_e_i = $urandom;
            tick();
            $display("mix %0d: pc_f=0x%08h pc_d=0x%08h valid_d=%0b", i, pc_f_o, pc_d_o, valid_d_o);
        end
        idle();

`ifdef FETCH_PERF_EN
        // T6 performance counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_fetch", perf_fetch_cnt_o, 32'h0);
        repeat (5) tick();
        stall_f_i = 1'b1; stall_d_i = 1'b1;
        repeat (2) tick();
        idle();
        flush_d_i = 1'b1;
        tick();
        idle();
        $display("T6 perf: fetch=%0d stall=%0d flush=%0d", perf_fetch_cnt_o, perf_stall_cnt_o, perf_flush_cnt_o);
        chk("t6_fetch", perf_fetch_cnt_o, 32'd5);
        chk("t6_stall", perf_stall_cnt_o, 32'd2);
        chk("t6_flush", perf_flush_cnt_o, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("T6 mid-run reset: fetch=%0d stall=%0d flush=%0d", perf_fetch_cnt_o, perf_stall_cnt_o, perf_flush_cnt_o);
        chk("t6_clr_fetch", perf_fetch_cnt_o, 32'd0);
        chk("t6_clr_stall", perf_stall_cnt_o, 32'd0);
        chk("t6_clr_flush", perf_flush_cnt_o, 32'd0);
`endif

        tick();
        @(negedge clk);
        cmp_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
